// File: rtl/inc_counter_pkg.sv
// Shared types and constants for the registered 4-bit up-counter.
package inc_counter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/inc_counter_4bit_incrementer.sv
// Combinational 4-bit +1 datapath; carry_out flags the 15 -> 0 rollover.
module incrementer_4bit
  import inc_counter_pkg::*;
(
  input  logic [CNT_W-1:0] in,
  output logic [CNT_W-1:0] out,
  output logic             carry_out
);

  always_comb begin
    {carry_out, out} = {1'b0, in} + {{CNT_W{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/inc_counter_4bit.sv
// Registered modulo/saturating up-counter around incrementer_4bit, with
// load/clear, terminal-count flag, one-cycle wrap pulse and sticky overflow.
module inc_counter_4bit
  import inc_counter_pkg::*;
#(
  parameter logic [3:0] MAX_VAL  = 4'd15,
  parameter bit         SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_max,
  output logic             wrap,
  output logic             overflow,
  output logic             running
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

  cnt_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             at_max_q;
  logic             wrap_q, wrap_d;
  logic             overflow_q, overflow_d;
  logic             running_q;

  logic [CNT_W-1:0] inc_out;
  logic             inc_carry;
  logic             at_term;

  incrementer_4bit u_inc (
    .in        (count_q),
    .out       (inc_out),
    .carry_out (inc_carry)
  );

  assign at_term = (count_q == MAX_C);

  always_comb begin
    count_d    = count_q;
    state_d    = state_q;
    overflow_d = overflow_q;
    wrap_d     = 1'b0;
    if (clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
      state_d    = IDLE;
    end else if (load) begin
      count_d    = (load_val > MAX_C) ? MAX_C : load_val;
      overflow_d = 1'b0;
      state_d    = en ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (!en) begin
            state_d = IDLE;
          end else if (!at_term) begin
            count_d = inc_out;
            state_d = RUN;
          end else if (SATURATE) begin
            state_d    = SAT;
            overflow_d = 1'b1;
          end else begin
            count_d    = '0;
            wrap_d     = 1'b1;
            overflow_d = 1'b1;
            state_d    = RUN;
          end
        end
        SAT:     state_d = SAT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      at_max_q   <= 1'b0;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      at_max_q   <= (count_d == MAX_C);
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
      running_q  <= (state_d == RUN);
    end
  end

  // The incrementer carry must agree with the terminal compare at 15.
  a_carry_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    inc_carry == (count_q == 4'hF));

  assign count    = count_q;
  assign at_max   = at_max_q;
  assign wrap     = wrap_q;
  assign overflow = overflow_q;
  assign running  = running_q;

endmodule
